fact_req_ctrl: RTL and testbench



---
 rtl/fact_req_ctrl.sv | 130 +++++++++++++
 tb/tb_fact_req_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fact_req_ctrl.sv
// Request/response front end for the factorial accelerator: range-checks operands,
// drives the accelerator handshake and returns results. Optional watchdog: FACT_TIMEOUT_EN.
module fact_req_ctrl #(
    parameter int DATA_W  = 32,
    parameter int N_W     = 4,
    parameter int MAX_N   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N_W-1:0]    req_n,
    output logic              dp_go,
    output logic [N_W-1:0]    dp_n,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        txn_cnt
);

    // state | meaning
    // IDLE  | ready for a request
    // ISSUE | one-cycle go pulse to the accelerator
    // WAIT  | waiting for the accelerator to finish
    // RESP  | response held until downstream accepts
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [N_W-1:0]    MAX_N_V = N_W'(MAX_N);
    localparam logic [N_W-1:0]    ONE_N   = N_W'(1);
    localparam logic [DATA_W-1:0] ONE_R   = DATA_W'(1);

    state_t         state;
    logic [N_W-1:0] n_q;

`ifdef FACT_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wd_q;
`endif

    assign dp_n = n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_q        <= '0;
            req_ready  <= 1'b1;
            dp_go      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            txn_cnt    <= '0;
`ifdef FACT_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        n_q       <= req_n;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_n > MAX_N_V) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                        end else if (req_n <= ONE_N) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= ONE_R;
                            rsp_err    <= 1'b0;
                        end else begin
                            state <= ISSUE;
                            dp_go <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    dp_go <= 1'b0;
`ifdef FACT_TIMEOUT_EN
                    wd_q  <= '0;
`endif
                end
                WAIT: begin
                    // dp_done takes priority over an expiring watchdog
                    if (dp_done) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= dp_result;
                        rsp_err    <= 1'b0;
                    end
`ifdef FACT_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        txn_cnt   <= txn_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    dp_go     <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_req_ctrl.sv
// Directed self-checking bench for fact_req_ctrl; timeout checks follow FACT_TIMEOUT_EN.
module tb_fact_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_n = '0;
    logic        dp_go;
    logic [3:0]  dp_n;
    logic        dp_done = 1'b0;
    logic [31:0] dp_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  txn_cnt;

    int total = 0;
    int bad = 0;
    int go_cnt = 0;
    int go_snap;
    logic [7:0] exp_txn = 8'd0;

    fact_req_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .dp_go(dp_go), .dp_n(dp_n), .dp_done(dp_done), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && dp_go) go_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_txn = exp_txn + 8'd1;
        chk("hs_valid_low", 32'(rsp_valid), 32'd0);
        chk("hs_req_ready", 32'(req_ready), 32'd1);
        chk("hs_txn_cnt", 32'(txn_cnt), 32'(exp_txn));
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_go", 32'(dp_go), 32'd0);
        chk("rst_dp_n", 32'(dp_n), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);

        // normal: 5! with done four cycles after go
        req_n = 4'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("n5_go", 32'(dp_go), 32'd1);
        chk("n5_dp_n", 32'(dp_n), 32'd5);
        chk("n5_busy", 32'(busy), 32'd1);
        chk("n5_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("n5_go_low", 32'(dp_go), 32'd0);
        tick();
        tick();
        chk("n5_dp_n_wait", 32'(dp_n), 32'd5);
        chk("n5_no_rsp", 32'(rsp_valid), 32'd0);
        dp_done = 1'b1; dp_result = 32'd120;
        tick();
        dp_done = 1'b0; dp_result = 32'd0;
        chk("n5_valid", 32'(rsp_valid), 32'd1);
        chk("n5_result", rsp_result, 32'd120);
        chk("n5_err", 32'(rsp_err), 32'd0);
        handshake();
        chk("n5_go_pulses", 32'(go_cnt), 32'd1);

        // short-circuit operands
        go_snap = go_cnt;
        req_n = 4'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("n0_valid", 32'(rsp_valid), 32'd1);
        chk("n0_result", rsp_result, 32'd1);
        chk("n0_err", 32'(rsp_err), 32'd0);
        handshake();
        req_n = 4'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("n1_valid", 32'(rsp_valid), 32'd1);
        chk("n1_result", rsp_result, 32'd1);
        chk("n1_err", 32'(rsp_err), 32'd0);
        handshake();
        req_n = 4'd13; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("n13_valid", 32'(rsp_valid), 32'd1);
        chk("n13_result", rsp_result, 32'd0);
        chk("n13_err", 32'(rsp_err), 32'd1);
        handshake();
        chk("sc_no_go", 32'(go_cnt), 32'(go_snap));

        // backpressure on 12!, done directly after ISSUE
        req_n = 4'd12; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        dp_done = 1'b1; dp_result = 32'd479001600;
        tick();
        dp_done = 1'b0; dp_result = 32'd0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", rsp_result, 32'd479001600);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        handshake();

        // reset mid-WAIT, then a stray done
        req_n = 4'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_txn = 8'd0;
        dp_done = 1'b1; dp_result = 32'd720;
        tick();
        dp_done = 1'b0;
        tick();
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_dp_go", 32'(dp_go), 32'd0);
        chk("rw_dp_n", 32'(dp_n), 32'd0);
        chk("rw_txn_cnt", 32'(txn_cnt), 32'd0);

`ifdef FACT_TIMEOUT_EN
        // watchdog expiry after 64 WAIT cycles
        req_n = 4'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 63; i++) tick();
        chk("to_not_yet", 32'(rsp_valid), 32'd0);
        tick();
        chk("to_valid", 32'(rsp_valid), 32'd1);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_result", rsp_result, 32'd0);
        handshake();
        // done on the exact timeout cycle wins
        req_n = 4'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 63; i++) tick();
        chk("tw_not_yet", 32'(rsp_valid), 32'd0);
        dp_done = 1'b1; dp_result = 32'd5040;
        tick();
        dp_done = 1'b0; dp_result = 32'd0;
        chk("tw_valid", 32'(rsp_valid), 32'd1);
        chk("tw_err", 32'(rsp_err), 32'd0);
        chk("tw_result", rsp_result, 32'd5040);
        handshake();
`else
        // no watchdog: WAIT persists well past the timeout length
        req_n = 4'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        chk("nw_still_busy", 32'(busy), 32'd1);
        chk("nw_no_rsp", 32'(rsp_valid), 32'd0);
        dp_done = 1'b1; dp_result = 32'd5040;
        tick();
        dp_done = 1'b0; dp_result = 32'd0;
        chk("nw_valid", 32'(rsp_valid), 32'd1);
        chk("nw_err", 32'(rsp_err), 32'd0);
        chk("nw_result", rsp_result, 32'd5040);
        handshake();
`endif

        // 256 back-to-back trivial transactions wrap the counter
        req_n = 4'd1; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("wrap_valid", 32'(rsp_valid), 32'd1);
            if (i == 255) req_valid = 1'b0;
            tick();
            chk("wrap_ready", 32'(req_ready), 32'd1);
        end
        rsp_ready = 1'b0;
        chk("wrap_txn_cnt", 32'(txn_cnt), 32'(exp_txn));
        tick();
        chk("wrap_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
